// File: rtl/img_pkg.sv
`default_nettype none
// ============================================================================
// Package     : img_pkg
// Description : Shared types and constants for the cross-window pixel path
//               (window fetch unit and the execution-stage max comparator).
// Revision    : 1.0 - initial release
// ============================================================================
package img_pkg;

  // Window fetch sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    LAST  = 2'd2,
    VALID = 2'd3
  } state_t;

  // Read slots, issued in this order
  typedef enum logic [2:0] {
    CENTRE = 3'd0,
    UP     = 3'd1,
    DOWN   = 3'd2,
    LEFT   = 3'd3,
    RIGHT  = 3'd4
  } slot_t;

  localparam int PIXEL_W    = 8;
  localparam int WINDOW_W   = 40;
  localparam int CENTRE_LSB = 32;
  localparam int UP_LSB     = 24;
  localparam int DOWN_LSB   = 16;
  localparam int LEFT_LSB   = 8;
  localparam int RIGHT_LSB  = 0;

  // Bit offset of a slot's byte inside the window bus
  function automatic logic [5:0] slot_lsb(input slot_t s);
    case (s)
      CENTRE:  slot_lsb = 6'(CENTRE_LSB);
      UP:      slot_lsb = 6'(UP_LSB);
      DOWN:    slot_lsb = 6'(DOWN_LSB);
      LEFT:    slot_lsb = 6'(LEFT_LSB);
      default: slot_lsb = 6'(RIGHT_LSB);
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_window_fetch_if.sv
`default_nettype none
// ============================================================================
// Interface   : pixel_window_fetch_if
// Description : Request, memory-read and window-output signals of the
//               cross-window fetch unit. master = requester/memory side,
//               slave = fetch unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface pixel_window_fetch_if #(
  parameter int ADDR_W = 32
);
  import img_pkg::*;

  logic                start;
  logic [ADDR_W-1:0]   center_addr;
  logic [15:0]         row;
  logic [15:0]         col;
  logic                mem_rd;
  logic [ADDR_W-1:0]   mem_addr;
  logic [PIXEL_W-1:0]  mem_data;
  logic [WINDOW_W-1:0] window;
  logic                out_valid;
  logic                out_ready;
  logic                busy;

  modport master (
    output start, center_addr, row, col, mem_data, out_ready,
    input  mem_rd, mem_addr, window, out_valid, busy
  );

  modport slave (
    input  start, center_addr, row, col, mem_data, out_ready,
    output mem_rd, mem_addr, window, out_valid, busy
  );

endinterface
`default_nettype wire

// File: rtl/window_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : window_addr_gen
// Description : Maps a read slot and the centre pixel position to a byte
//               address and flags neighbours that fall outside the image.
// Revision    : 1.0 - initial release
// ============================================================================
module window_addr_gen
  import img_pkg::*;
#(
  parameter int IMG_W  = 320,
  parameter int IMG_H  = 240,
  parameter int ADDR_W = 32
) (
  input  wire slot_t             i_slot,
  input  wire logic [ADDR_W-1:0] i_center_addr,
  input  wire logic [15:0]       i_row,
  input  wire logic [15:0]       i_col,
  output logic      [ADDR_W-1:0] o_addr,
  output logic                   o_in_range
);

  localparam logic [ADDR_W-1:0] c_stride  = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] c_one     = ADDR_W'(1);
  localparam logic [15:0]       c_row_max = 16'(IMG_H - 1);
  localparam logic [15:0]       c_col_max = 16'(IMG_W - 1);

  // Neighbour address (wraps modulo 2^ADDR_W) and border check
  always_comb begin
    o_addr     = i_center_addr;
    o_in_range = 1'b1;
    case (i_slot)
      UP: begin
        o_addr     = i_center_addr - c_stride;
        o_in_range = (i_row != 16'd0);
      end
      DOWN: begin
        o_addr     = i_center_addr + c_stride;
        o_in_range = (i_row != c_row_max);
      end
      LEFT: begin
        o_addr     = i_center_addr - c_one;
        o_in_range = (i_col != 16'd0);
      end
      RIGHT: begin
        o_addr     = i_center_addr + c_one;
        o_in_range = (i_col != c_col_max);
      end
      default: begin
        o_addr     = i_center_addr;
        o_in_range = 1'b1;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/pixel_window_fetch.sv
`default_nettype none
// ============================================================================
// Module      : pixel_window_fetch
// Description : Fetches the five-pixel cross window around a centre pixel
//               with five fixed-slot byte reads, substituting the centre
//               byte for neighbours beyond the image border.
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_window_fetch
  import img_pkg::*;
#(
  parameter int IMG_W  = 320,
  parameter int IMG_H  = 240,
  parameter int ADDR_W = 32
) (
  input wire logic              clk,
  input wire logic              reset,
  pixel_window_fetch_if.slave   bus
);

  state_t              r_state;
  slot_t               r_slot;
  logic [ADDR_W-1:0]   r_center_addr;
  logic [15:0]         r_row;
  logic [15:0]         r_col;
  logic                r_mem_rd;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic                r_rd_d;
  logic [WINDOW_W-1:0] r_window;
  logic                r_out_valid;
  logic                r_busy;

  slot_t               w_next_slot;
  logic [ADDR_W-1:0]   w_next_addr;
  logic                w_next_in_range;
  slot_t               w_cap_slot;
  logic [5:0]          w_cap_lsb;
  logic [PIXEL_W-1:0]  w_cap_byte;
  logic                w_accept;

  // Address of the slot to be issued on the next cycle
  assign w_next_slot = slot_t'(r_slot + 3'd1);

  window_addr_gen #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .i_slot        (w_next_slot),
    .i_center_addr (r_center_addr),
    .i_row         (r_row),
    .i_col         (r_col),
    .o_addr        (w_next_addr),
    .o_in_range    (w_next_in_range)
  );

  // Data returning this cycle belongs to the slot issued one cycle earlier;
  // a slot that was skipped at the border takes the already-captured centre.
  assign w_cap_slot = (r_state == LAST) ? RIGHT : slot_t'(r_slot - 3'd1);
  assign w_cap_lsb  = slot_lsb(w_cap_slot);
  assign w_cap_byte = r_rd_d ? bus.mem_data : r_window[CENTRE_LSB +: PIXEL_W];

  // New request accepted from IDLE, or from VALID as the window is consumed
  assign w_accept = bus.start &&
                    ((r_state == IDLE) || ((r_state == VALID) && bus.out_ready));

  // Sequencer: issue slots, capture bytes, present and hand off the window
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_slot        <= CENTRE;
      r_center_addr <= '0;
      r_row         <= '0;
      r_col         <= '0;
      r_mem_rd      <= 1'b0;
      r_mem_addr    <= '0;
      r_rd_d        <= 1'b0;
      r_window      <= '0;
      r_out_valid   <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_rd_d <= r_mem_rd;
      if (w_accept) begin
        r_center_addr <= bus.center_addr;
        r_row         <= bus.row;
        r_col         <= bus.col;
        r_slot        <= CENTRE;
        r_mem_rd      <= 1'b1;
        r_mem_addr    <= bus.center_addr;
        r_out_valid   <= 1'b0;
        r_busy        <= 1'b1;
        r_state       <= FETCH;
      end else begin
        case (r_state)
          FETCH: begin
            if (r_slot != CENTRE) begin
              r_window[w_cap_lsb +: PIXEL_W] <= w_cap_byte;
            end
            if (r_slot == RIGHT) begin
              r_mem_rd <= 1'b0;
              r_state  <= LAST;
            end else begin
              r_slot     <= w_next_slot;
              r_mem_rd   <= w_next_in_range;
              r_mem_addr <= w_next_addr;
            end
          end
          LAST: begin
            r_window[w_cap_lsb +: PIXEL_W] <= w_cap_byte;
            r_out_valid <= 1'b1;
            r_state     <= VALID;
          end
          VALID: begin
            if (bus.out_ready) begin
              r_out_valid <= 1'b0;
              r_busy      <= 1'b0;
              r_state     <= IDLE;
            end
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.mem_rd    = r_mem_rd;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.window    = r_window;
  assign bus.out_valid = r_out_valid;
  assign bus.busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_pixel_window_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_pixel_window_fetch
// Description : Directed self-checking bench for pixel_window_fetch.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_window_fetch;
  import img_pkg::*;

  localparam int IMG_W  = 320;
  localparam int IMG_H  = 240;
  localparam int ADDR_W = 32;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] rd_log [$];
  logic [7:0]  mem    [logic [31:0]];

  pixel_window_fetch_if #(.ADDR_W(ADDR_W)) bus ();

  pixel_window_fetch #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Byte memory: explicit entries, otherwise a fixed address pattern
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ 8'h5A;
  endfunction

  // One-cycle read latency; idle cycles return a poison value
  always @(posedge clk) bus.mem_data <= bus.mem_rd ? mem_byte(bus.mem_addr) : 8'hEE;

  // Log every issued read
  always @(negedge clk) if (bus.mem_rd === 1'b1) rd_log.push_back(bus.mem_addr);

  task automatic issue_req(input logic [31:0] a, input logic [15:0] r, input logic [15:0] c,
                           input bit keep_start);
    @(negedge clk);
    rd_log.delete();
    bus.center_addr = a;
    bus.row         = r;
    bus.col         = c;
    bus.start       = 1'b1;
    @(posedge clk);
    #1;
    if (!keep_start) bus.start = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 99;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic consume;
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL consume: out_valid=%b busy=%b, required 0 0", bus.out_valid, bus.busy);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (bus.window !== 40'h0) begin miscompares++; $display("FAIL reset_window: got %h want 0", bus.window); end
    vectors++;
    if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    vectors++;
    if (bus.mem_rd !== 1'b0) begin miscompares++; $display("FAIL reset_mem_rd: got %b want 0", bus.mem_rd); end
    vectors++;
    if (bus.mem_addr !== 32'h0) begin miscompares++; $display("FAIL reset_mem_addr: got %h want 0", bus.mem_addr); end
    vectors++;
    if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_interior;
    int lat;
    logic [31:0] exp_q [$];
    exp_q = '{32'h1000, 32'h0EC0, 32'h1140, 32'h0FFF, 32'h1001};
    issue_req(32'h1000, 16'd10, 16'd10, 1'b0);
    vectors++;
    if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL interior_busy: got %b want 1", bus.busy); end
    wait_valid(lat);
    vectors++;
    if (lat != 6) begin miscompares++; $display("FAIL interior_latency: got %0d want 6", lat); end
    vectors++;
    if (bus.window !== 40'h5011223344) begin miscompares++; $display("FAIL interior_window: got %h want 5011223344", bus.window); end
    vectors++;
    if (rd_log.size() != exp_q.size()) begin
      miscompares++; $display("FAIL interior_read_count: got %0d want %0d", rd_log.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        vectors++;
        if (rd_log[i] !== exp_q[i]) begin miscompares++; $display("FAIL interior_read_addr[%0d]: got %h want %h", i, rd_log[i], exp_q[i]); end
      end
    end
    consume();
  endtask

  task automatic test_top_left;
    int lat;
    logic [31:0] exp_q [$];
    exp_q = '{32'h2000, 32'h2140, 32'h2001};
    issue_req(32'h2000, 16'd0, 16'd0, 1'b0);
    wait_valid(lat);
    vectors++;
    if (lat != 6) begin miscompares++; $display("FAIL top_left_latency: got %0d want 6", lat); end
    vectors++;
    if (bus.window !== 40'h7F7F217F31) begin miscompares++; $display("FAIL top_left_window: got %h want 7f7f217f31", bus.window); end
    vectors++;
    if (rd_log.size() != exp_q.size()) begin
      miscompares++; $display("FAIL top_left_read_count: got %0d want %0d", rd_log.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        vectors++;
        if (rd_log[i] !== exp_q[i]) begin miscompares++; $display("FAIL top_left_read_addr[%0d]: got %h want %h", i, rd_log[i], exp_q[i]); end
      end
    end
    consume();
  endtask

  task automatic test_bottom_right(input string tag);
    int lat;
    logic [31:0] exp_q [$];
    exp_q = '{32'h4000, 32'h3EC0, 32'h3FFF};
    issue_req(32'h4000, 16'd239, 16'd319, 1'b0);
    wait_valid(lat);
    vectors++;
    if (lat != 6) begin miscompares++; $display("FAIL %s_latency: got %0d want 6", tag, lat); end
    vectors++;
    if (bus.window !== 40'hC312C334C3) begin miscompares++; $display("FAIL %s_window: got %h want c312c334c3", tag, bus.window); end
    vectors++;
    if (rd_log.size() != exp_q.size()) begin
      miscompares++; $display("FAIL %s_read_count: got %0d want %0d", tag, rd_log.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        vectors++;
        if (rd_log[i] !== exp_q[i]) begin miscompares++; $display("FAIL %s_read_addr[%0d]: got %h want %h", tag, i, rd_log[i], exp_q[i]); end
      end
    end
    consume();
  endtask

  task automatic test_backpressure;
    int lat;
    issue_req(32'h1000, 16'd10, 16'd10, 1'b0);
    wait_valid(lat);
    vectors++;
    if (lat != 6) begin miscompares++; $display("FAIL bp_latency: got %0d want 6", lat); end
    for (int n = 0; n < 4; n++) begin
      bus.start = (n == 1);
      @(posedge clk);
      #1;
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.mem_rd !== 1'b0 || bus.window !== 40'h5011223344) begin
        miscompares++;
        $display("FAIL bp_hold[%0d]: out_valid=%b mem_rd=%b window=%h, required 1 0 5011223344",
                 n, bus.out_valid, bus.mem_rd, bus.window);
      end
    end
    bus.start = 1'b0;
    vectors++;
    if (rd_log.size() != 5) begin miscompares++; $display("FAIL bp_reads: got %0d want 5", rd_log.size()); end
    // Consume and start the next request in the same cycle
    @(negedge clk);
    rd_log.delete();
    bus.center_addr = 32'h6000;
    bus.row         = 16'd5;
    bus.col         = 16'd7;
    bus.start       = 1'b1;
    bus.out_ready   = 1'b1;
    @(posedge clk);
    #1;
    bus.start     = 1'b0;
    bus.out_ready = 1'b0;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b1) begin
      miscompares++; $display("FAIL b2b_accept: out_valid=%b busy=%b, required 0 1", bus.out_valid, bus.busy);
    end
    wait_valid(lat);
    vectors++;
    if (lat != 6) begin miscompares++; $display("FAIL b2b_latency: got %0d want 6", lat); end
    vectors++;
    if (bus.window !== 40'h5A9A1AA55B) begin miscompares++; $display("FAIL b2b_window: got %h want 5a9a1aa55b", bus.window); end
    vectors++;
    if (rd_log.size() != 5) begin miscompares++; $display("FAIL b2b_reads: got %0d want 5", rd_log.size()); end
    consume();
  endtask

  task automatic test_reset_mid_fetch;
    issue_req(32'h1000, 16'd10, 16'd10, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    vectors++;
    if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 32'h1140) begin
      miscompares++; $display("FAIL abort_slot2: mem_rd=%b mem_addr=%h, required 1 00001140", bus.mem_rd, bus.mem_addr);
    end
    #1;
    reset = 1'b1;
    #1;
    vectors++;
    if (bus.window !== 40'h0 || bus.out_valid !== 1'b0 || bus.mem_rd !== 1'b0 ||
        bus.mem_addr !== 32'h0 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_outputs: window=%h out_valid=%b mem_rd=%b mem_addr=%h busy=%b, required all 0",
               bus.window, bus.out_valid, bus.mem_rd, bus.mem_addr, bus.busy);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    test_bottom_right("after_abort");
  endtask

  task automatic test_start_during_fetch;
    int lat;
    issue_req(32'h1000, 16'd10, 16'd10, 1'b1);
    bus.center_addr = 32'h7000;
    bus.row         = 16'd3;
    bus.col         = 16'd3;
    wait_valid(lat);
    vectors++;
    if (lat != 6) begin miscompares++; $display("FAIL sdf_latency: got %0d want 6", lat); end
    vectors++;
    if (bus.window !== 40'h5011223344) begin miscompares++; $display("FAIL sdf_window: got %h want 5011223344", bus.window); end
    repeat (3) @(posedge clk);
    #1;
    bus.start = 1'b0;
    vectors++;
    if (rd_log.size() != 5) begin miscompares++; $display("FAIL sdf_read_count: got %0d want 5", rd_log.size()); end
    vectors++;
    if (rd_log.size() == 5 && rd_log[0] !== 32'h1000) begin
      miscompares++; $display("FAIL sdf_first_addr: got %h want 00001000", rd_log[0]);
    end
    consume();
  endtask

  initial begin
    bus.start       = 1'b0;
    bus.center_addr = '0;
    bus.row         = '0;
    bus.col         = '0;
    bus.out_ready   = 1'b0;
    mem[32'h1000] = 8'h50;
    mem[32'h0EC0] = 8'h11;
    mem[32'h1140] = 8'h22;
    mem[32'h0FFF] = 8'h33;
    mem[32'h1001] = 8'h44;
    mem[32'h2000] = 8'h7F;
    mem[32'h2140] = 8'h21;
    mem[32'h2001] = 8'h31;
    mem[32'h1EC0] = 8'h99;
    mem[32'h1FFF] = 8'h98;
    mem[32'h4000] = 8'hC3;
    mem[32'h3EC0] = 8'h12;
    mem[32'h3FFF] = 8'h34;
    mem[32'h4140] = 8'hAA;
    mem[32'h4001] = 8'hBB;

    test_reset();
    test_interior();
    test_top_left();
    test_bottom_right("bottom_right");
    test_backpressure();
    test_reset_mid_fetch();
    test_start_during_fetch();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
